// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: forwarding selects and MDU FSM states.
package hazard_pkg;

    // EX-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Multi-cycle MDU occupancy of E
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    // Load-use bubble counter width; LOAD_LAT is at most 3
    localparam int unsigned LU_CNT_W = 2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX operand's forwarding comparator and M-over-W priority mux.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired zero, so it never forwards
    assign hit_m = reg_write_m && (rs_e != '0) && (rs_e == rd_m);
    assign hit_w = reg_write_w && (rs_e != '0) && (rs_e == rd_w);

    // M result is younger than W, so it wins when both match
    always_comb begin
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage RV32I pipeline: EX forwarding, branch flushes,
// programmable load-use bubbles, multi-cycle MDU stall and a stall counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              load_e,
    input  logic              mdu_start_e,
    input  logic              pc_src_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned MCntW = $clog2(MDU_LAT + 1);

    mdu_state_t          state_q;
    logic [MCntW-1:0]    mcnt_q;
    logic [LU_CNT_W-1:0] lu_cnt_q;
    logic [LU_CNT_W-1:0] lu_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                lu_hit;
    logic                lu_pend;
    logic                mdu_act;

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_a)
    );

    hazard_fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .sel         (fwd_b)
    );

    assign lu_hit  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign lu_pend = (lu_cnt_q != '0);
    // Stall covers the start cycle too, before the FSM has left IDLE
    assign mdu_act = (state_q == BUSY) || mdu_start_e;

    // Priority resolution: MDU hold > branch flush > load-use bubble
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        mdu_busy    = 1'b0;
        if (!reset) begin
            forward_a_e = fwd_a;
            forward_b_e = fwd_b;
            if (mdu_act) begin
                // A branch cannot resolve while E is held; pc_src_e is ignored
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                stall_e  = 1'b1;
                flush_m  = 1'b1;
                mdu_busy = 1'b1;
            end else if (pc_src_e) begin
                // The dependent instruction is squashed, so no bubble is needed
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu_hit || lu_pend) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Next load-use bubble count; frozen while the MDU holds E
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (mdu_act) begin
            lu_cnt_d = lu_cnt_q;
        end else if (pc_src_e) begin
            lu_cnt_d = '0;
        end else if (lu_hit) begin
            lu_cnt_d = LU_CNT_W'(LOAD_LAT - 1);
        end else if (lu_pend) begin
            lu_cnt_d = lu_cnt_q - 1'b1;
        end
    end

    // Load-use bubble counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // MDU FSM: start cycle plus MDU_LAT-1 BUSY cycles hold E for MDU_LAT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_start_e) begin
                        state_q <= BUSY;
                        mcnt_q  <= MCntW'(MDU_LAT - 1);
                    end
                end
                BUSY: begin
                    if (mcnt_q == MCntW'(1)) begin
                        state_q <= IDLE;
                        mcnt_q  <= '0;
                    end else begin
                        mcnt_q <= mcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mcnt_q  <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
